// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: segment type, glyph table and blank pattern.
package sevenseg_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned GLYPH_N = 16;

  // Segment pattern, active-high, bit0=a ... bit6=g.
  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t BLANK = 7'h00;

  // Entry i is the glyph that displays hex value i.
  localparam seg_t GLYPH_TAB [GLYPH_N] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/sevenseg_reader_if.sv
// Display-side pins and decoded results of the seven-segment reader.
interface sevenseg_reader_if #(
  parameter int unsigned DIGITS = 4
);
  import sevenseg_pkg::*;

  seg_t                    sevenseg_n;
  logic [DIGITS-1:0]       digit_en_n;
  logic [NIB_W*DIGITS-1:0] hex;
  logic [DIGITS-1:0]       valid;
  logic [DIGITS-1:0]       err;
  logic                    update;
  logic                    sel_err;

  modport master (
    output sevenseg_n, digit_en_n,
    input  hex, valid, err, update, sel_err
  );

  modport slave (
    input  sevenseg_n, digit_en_n,
    output hex, valid, err, update, sel_err
  );

endinterface

// File: rtl/sevenseg_inv.sv
// Inverse glyph lookup: segment pattern to hex value plus legal/blank flags.
module sevenseg_inv
  import sevenseg_pkg::*;
(
  input  seg_t             seg,
  output logic [NIB_W-1:0] value_c,
  output logic             legal_c,
  output logic             blank_c
);

  // Search the glyph table; the table entries are unique so at most one hits.
  always_comb begin
    value_c = '0;
    legal_c = 1'b0;
    for (int unsigned i = 0; i < GLYPH_N; i++) begin
      if (seg == GLYPH_TAB[i]) begin
        value_c = NIB_W'(i);
        legal_c = 1'b1;
      end
    end
    blank_c = (seg == BLANK);
  end

endmodule

// File: rtl/sevenseg_reader.sv
// Reads a multiplexed seven-segment display back into per-digit hex values,
// committing a digit only after its pattern has been seen stably.
module sevenseg_reader
  import sevenseg_pkg::*;
#(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned STABLE_CNT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  sevenseg_reader_if.slave bus
);

  localparam int unsigned      IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CNT);

  seg_t              seg_s1, seg_s2;
  logic [DIGITS-1:0] en_s1, en_s2;

  seg_t              cand_q [DIGITS];
  logic [CNT_W-1:0]  cnt_q  [DIGITS];

  seg_t              sample_c;
  logic [DIGITS-1:0] sel_c;
  logic              one_hot_c;
  logic [IDX_W-1:0]  idx_c;
  logic              hit_c;
  logic [CNT_W-1:0]  cnt_cur_c;
  logic [CNT_W-1:0]  cnt_next_c;
  logic              commit_c;

  logic              commit_q;
  logic [IDX_W-1:0]  commit_idx_q;
  seg_t              commit_seg_q;
  logic              sel_err_q;

  logic [NIB_W-1:0]        inv_value_c;
  logic                    inv_legal_c;
  logic                    inv_blank_c;

  logic [NIB_W*DIGITS-1:0] hex_q, hex_c;
  logic [DIGITS-1:0]       valid_q, valid_c;
  logic [DIGITS-1:0]       err_q, err_c;
  logic                    update_q;

  // Two-flop synchronizer; reset to the inactive (all ones) pin level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1 <= '1;
      seg_s2 <= '1;
      en_s1  <= '1;
      en_s2  <= '1;
    end else begin
      seg_s1 <= bus.sevenseg_n;
      seg_s2 <= seg_s1;
      en_s1  <= bus.digit_en_n;
      en_s2  <= en_s1;
    end
  end

  // Decode the sample: active-high pattern, one-hot check and selected index.
  always_comb begin
    sample_c  = ~seg_s2;
    sel_c     = ~en_s2;
    one_hot_c = (sel_c != '0) && ((sel_c & (sel_c - DIGITS'(1))) == '0);
    idx_c     = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (sel_c[i]) begin
        idx_c = IDX_W'(i);
      end
    end
  end

  // Next count for the selected digit and commit detection on reaching STABLE.
  always_comb begin
    cnt_cur_c = cnt_q[idx_c];
    hit_c     = (sample_c == cand_q[idx_c]);
    if (hit_c) begin
      cnt_next_c = (cnt_cur_c >= STABLE) ? STABLE : (cnt_cur_c + CNT_W'(1));
    end else begin
      cnt_next_c = CNT_W'(1);
    end
    // A digit already saturated on the same pattern must not commit again.
    commit_c = one_hot_c && (cnt_next_c == STABLE) && !(hit_c && (cnt_cur_c == STABLE));
  end

  // Per-digit candidate pattern and saturating stability count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        cand_q[i] <= BLANK;
        cnt_q[i]  <= '0;
      end
    end else if (one_hot_c) begin
      cand_q[idx_c] <= sample_c;
      cnt_q[idx_c]  <= cnt_next_c;
    end
  end

  // Commit request and select-error pulse, registered one cycle after the sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_q     <= 1'b0;
      commit_idx_q <= '0;
      commit_seg_q <= BLANK;
      sel_err_q    <= 1'b0;
    end else begin
      commit_q  <= commit_c;
      sel_err_q <= !one_hot_c;
      if (commit_c) begin
        commit_idx_q <= idx_c;
        commit_seg_q <= sample_c;
      end
    end
  end

  sevenseg_inv u_inv (
    .seg     (commit_seg_q),
    .value_c (inv_value_c),
    .legal_c (inv_legal_c),
    .blank_c (inv_blank_c)
  );

  // Next output state: apply a pending commit to its digit; hex held unless legal.
  always_comb begin
    hex_c   = hex_q;
    valid_c = valid_q;
    err_c   = err_q;
    if (commit_q) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (commit_idx_q == IDX_W'(i)) begin
          valid_c[i] = inv_legal_c;
          err_c[i]   = !inv_legal_c && !inv_blank_c;
          if (inv_legal_c) begin
            hex_c[NIB_W*i +: NIB_W] = inv_value_c;
          end
        end
      end
    end
  end

  // Output registers; update pulses only when something visibly changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_q    <= '0;
      valid_q  <= '0;
      err_q    <= '0;
      update_q <= 1'b0;
    end else begin
      hex_q    <= hex_c;
      valid_q  <= valid_c;
      err_q    <= err_c;
      update_q <= (hex_c != hex_q) || (valid_c != valid_q) || (err_c != err_q);
    end
  end

  assign bus.hex     = hex_q;
  assign bus.valid   = valid_q;
  assign bus.err     = err_q;
  assign bus.update  = update_q;
  assign bus.sel_err = sel_err_q;

endmodule

// File: doc/sevenseg_reader.md
SEVENSEG_READER -- requirements
Module: sevenseg_reader

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed digit positions.
REQ-002 Parameter STABLE_CNT, default 3, range 1..15: consecutive identical samples a digit needs before its value commits.
REQ-003 clk  input  1: single clock; all state is on the rising edge.
REQ-004 rst_n  input  1: asynchronous, active-low reset.
REQ-005 sevenseg_n  input  7: active-low segment lines from the display; bit0=a … bit6=g; asynchronous to clk.
REQ-006 digit_en_n  input  DIGITS: active-low digit select; exactly one bit low selects that digit.
REQ-007 hex  output  4*DIGITS: committed hex value; digit i occupies bits [4i+3:4i].
REQ-008 valid  output  DIGITS: the committed pattern of digit i is a legal hex glyph.
REQ-009 err  output  DIGITS: the committed pattern of digit i is non-blank and not a legal glyph.
REQ-010 update  output  1: one-cycle pulse when any hex/valid/err bit changes.
REQ-011 sel_err  output  1: one-cycle pulse for a sample with zero or more than one digit selected.

Function
REQ-012 sevenseg_n and digit_en_n SHALL pass through a 2-flop synchronizer; the second-stage value is the "sample" for that cycle.
REQ-013 Legal glyphs, gfedcba active-high: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-014 Blank glyph = 00; every other pattern is illegal.
REQ-015 Each digit SHALL hold a candidate pattern (7 bits) and a 4-bit saturating count.
REQ-016 Sample with exactly one select low (digit k): if the pattern equals candidate[k], count[k] increments, saturating at STABLE_CNT; otherwise candidate[k] is loaded and count[k] becomes 1.
REQ-017 Non-selected digits SHALL keep candidate and count unchanged.
REQ-018 Zero or multiple selects: no candidate or count changes; sel_err pulses the following cycle.
REQ-019 Commit occurs on the cycle count[k] reaches STABLE_CNT; outputs update one cycle later (latency from pin change = 2 sync + STABLE_CNT samples + 1).
REQ-020 Commit of a legal glyph: hex digit = decoded value, valid=1, err=0.
REQ-021 Commit of blank: valid=0, err=0, hex digit held.
REQ-022 Commit of an illegal pattern: valid=0, err=1, hex digit held.
REQ-023 A saturated count SHALL NOT re-commit; update pulses only on an actual output change.
REQ-024 With STABLE_CNT=1, every new pattern commits on its first sample.
REQ-025 Commits on different digits in the same cycle are impossible (one digit per sample); commit and sel_err never coincide.

Reset
REQ-026 rst_n low SHALL asynchronously clear: synchronizer flops to all-inactive (ones), candidates to 00, counts to 0, hex=0, valid=0, err=0, update=0, sel_err=0.
REQ-027 Reset asserted mid-accumulation SHALL discard partial counts; after release, a digit needs a full STABLE_CNT samples again.
REQ-028 Reset deassertion SHALL take effect on the first rising clk edge after rst_n rises.

Structure
REQ-029 Package sevenseg_pkg SHALL hold the 16-entry glyph table constant, the BLANK constant, and a seg_t (7-bit) typedef shared with the existing sevenseg decoder.
REQ-030 Sub-module sevenseg_inv (combinational: seg_t in -> 4-bit value, legal, blank) SHALL perform the glyph inverse lookup; the main module holds all state.

Verification
REQ-031 Reset, then drive digit 0 select with pattern 3F for 3 cycles -> after latency hex[3:0]=0, valid[0]=1, one update pulse.
REQ-032 Scan 4 digits round-robin with 4F,5B,06,71, each selected 3 times -> hex=16'hF123 (digit3..0 = F,1,2,3), valid=4'hF, exactly 4 update pulses.
REQ-033 Digit 2 pattern 7D for 2 samples, then 6D for 3 -> candidate reloads; hex[11:8] commits 5, never 6.
REQ-034 Digit 1 pattern 49 for 3 samples -> err[1]=1, valid[1]=0, hex[7:4] unchanged; then 00 for 3 samples -> err[1]=0, valid[1]=0.
REQ-035 digit_en_n=4'b1111, then 4'b1100 -> two sel_err pulses, no count or output change.
REQ-036 Assert rst_n low after 2 of 3 samples of 7F on digit 3, release, apply 7F once -> no commit; 2 more samples -> hex[15:12]=8.
